// File: rtl/npu_pkt_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkt_pkg
// Shared definitions for the NPU-side packet buffer.
//   - state_e      : buffer FSM encoding (IDLE / WRITE / READ)
//   - DEPTH        : default packet capacity in words
//   - ADDR_W       : default log2(DEPTH)
//   - DATA_W       : default word width
// -----------------------------------------------------------------------------
package npu_pkt_pkg;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

endpackage

// File: rtl/npu_pkt_ram.sv
// -----------------------------------------------------------------------------
// npu_pkt_ram
// DEPTH x DATA_W register array with one write port and one registered read
// port. The read register clears to 0 on any cycle without a read so that the
// buffer's read data is 0 whenever no beat is being issued.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (read register only)
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write data
//   i_re       : read enable
//   i_raddr    : read address
//   o_rdata    : registered read data (0 when the previous cycle had no read)
// -----------------------------------------------------------------------------
module npu_pkt_ram
   import npu_pkt_pkg::*;
#(
   parameter int P_DEPTH  = DEPTH,
   parameter int P_ADDR_W = ADDR_W,
   parameter int P_DATA_W = DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_we,
   input  logic [P_ADDR_W-1:0] i_waddr,
   input  logic [P_DATA_W-1:0] i_wdata,
   input  logic                i_re,
   input  logic [P_ADDR_W-1:0] i_raddr,
   output logic [P_DATA_W-1:0] o_rdata
);

   logic [P_DATA_W-1:0] r_mem [P_DEPTH];
   logic [P_DATA_W-1:0] r_rdata;

   // Array contents are don't-care after reset, so no reset on the storage.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end else begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/npu_pkt_buffer.sv
// -----------------------------------------------------------------------------
// npu_pkt_buffer
// Stores one packet received on the bridge's NPU write-data channel and replays
// it on the NPU read-data channel when rd_sop is pulsed.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   wr_sop/wr_vld/wr_data/wr_eop : write channel in (packet start, beat, end)
//   wr_err                   : 1-cycle registered write error pulse
//   rd_sop                   : read request pulse (replay the whole packet)
//   rd_ready                 : read backpressure, one beat per ready cycle
//   rd_vld/rd_data/rd_eop    : registered read channel out
//   rd_err                   : 1-cycle registered read error pulse
//   pkt_len                  : word count of the stored packet
//   pkt_valid                : a complete, error-free packet is stored
//   dbg_state                : current FSM state (debug)
// Read channel handshake: a beat is issued on the cycle after each READ cycle
// with rd_ready=1; rd_vld marks that beat, rd_eop marks the last one, and
// rd_data is 0 whenever rd_vld is 0. There is no ready on the write channel:
// every wr_vld beat is either stored or reported via wr_err.
// -----------------------------------------------------------------------------
module npu_pkt_buffer
   import npu_pkt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_sop,
   input  logic              wr_vld,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_eop,
   output logic              wr_err,
   input  logic              rd_sop,
   input  logic              rd_ready,
   output logic              rd_vld,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_eop,
   output logic              rd_err,
   output logic [ADDR_W:0]   pkt_len,
   output logic              pkt_valid,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

   state_e            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_wptr, w_wptr_nxt;
   logic [ADDR_W:0]   r_rptr, w_rptr_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic [ADDR_W:0]   r_pkt_len, w_pkt_len_nxt;
   logic              r_pkt_valid, w_pkt_valid_nxt;
   logic              r_wr_err, w_wr_err_nxt;
   logic              r_rd_err, w_rd_err_nxt;
   logic              r_rd_vld, w_rd_vld_nxt;
   logic              r_rd_eop, w_rd_eop_nxt;

   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic              w_re;
   logic [DATA_W-1:0] w_rdata;

   // Write-side helpers: room left, length including a same-cycle beat,
   // and whether a same-cycle beat overflows.
   logic              w_room;
   logic [ADDR_W:0]   w_wlen;
   logic              w_ovf_hit;
   logic              w_ovf_all;

   assign w_room    = (r_wptr < L_DEPTH);
   assign w_wlen    = (wr_vld && w_room) ? (r_wptr + L_ONE) : r_wptr;
   assign w_ovf_hit = wr_vld && !w_room;
   assign w_ovf_all = r_ovf || w_ovf_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_wptr_nxt      = r_wptr;
      w_rptr_nxt      = r_rptr;
      w_ovf_nxt       = r_ovf;
      w_pkt_len_nxt   = r_pkt_len;
      w_pkt_valid_nxt = r_pkt_valid;
      w_wr_err_nxt    = 1'b0;
      w_rd_err_nxt    = 1'b0;
      w_rd_vld_nxt    = 1'b0;
      w_rd_eop_nxt    = 1'b0;
      w_we            = 1'b0;
      w_waddr         = r_wptr[ADDR_W-1:0];
      w_re            = 1'b0;

      case (r_state)
         IDLE: begin
            if (wr_sop) begin
               // Write wins over a simultaneous read request.
               w_state_nxt     = WRITE;
               w_wptr_nxt      = '0;
               w_ovf_nxt       = 1'b0;
               w_pkt_valid_nxt = 1'b0;
               w_rd_err_nxt    = rd_sop;
               if (wr_vld) begin
                  w_we       = 1'b1;
                  w_waddr    = '0;
                  w_wptr_nxt = L_ONE;
               end
            end else begin
               w_wr_err_nxt = wr_vld || wr_eop;
               if (rd_sop) begin
                  if (r_pkt_valid) begin
                     w_rptr_nxt  = '0;
                     w_state_nxt = READ;
                  end else begin
                     w_rd_err_nxt = 1'b1;
                  end
               end
            end
         end

         WRITE: begin
            w_rd_err_nxt = rd_sop;
            if (wr_eop) begin
               // End of packet closes it even if a sop arrives alongside.
               w_we            = wr_vld && w_room;
               w_pkt_len_nxt   = w_wlen;
               w_wptr_nxt      = w_wlen;
               w_ovf_nxt       = w_ovf_all;
               w_state_nxt     = IDLE;
               w_pkt_valid_nxt = !w_ovf_all && (w_wlen != '0);
               w_wr_err_nxt    = w_ovf_all || (w_wlen == '0);
            end else if (wr_sop) begin
               w_wr_err_nxt = 1'b1;
               w_wptr_nxt   = '0;
               w_ovf_nxt    = 1'b0;
               if (wr_vld) begin
                  w_we       = 1'b1;
                  w_waddr    = '0;
                  w_wptr_nxt = L_ONE;
               end
            end else if (wr_vld) begin
               w_we         = w_room;
               w_wptr_nxt   = w_wlen;
               w_ovf_nxt    = w_ovf_all;
               w_wr_err_nxt = w_ovf_hit;
            end
         end

         READ: begin
            // Any write activity is refused while replaying; the read goes on.
            w_wr_err_nxt = wr_sop || wr_vld || wr_eop;
            w_rd_err_nxt = rd_sop;
            if (rd_ready) begin
               w_re         = 1'b1;
               w_rd_vld_nxt = 1'b1;
               w_rd_eop_nxt = (r_rptr == (r_pkt_len - L_ONE));
               w_rptr_nxt   = r_rptr + L_ONE;
               if (w_rd_eop_nxt) begin
                  w_state_nxt = IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_ovf       <= 1'b0;
         r_pkt_len   <= '0;
         r_pkt_valid <= 1'b0;
         r_wr_err    <= 1'b0;
         r_rd_err    <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_rd_eop    <= 1'b0;
      end else begin
         r_wptr      <= w_wptr_nxt;
         r_rptr      <= w_rptr_nxt;
         r_ovf       <= w_ovf_nxt;
         r_pkt_len   <= w_pkt_len_nxt;
         r_pkt_valid <= w_pkt_valid_nxt;
         r_wr_err    <= w_wr_err_nxt;
         r_rd_err    <= w_rd_err_nxt;
         r_rd_vld    <= w_rd_vld_nxt;
         r_rd_eop    <= w_rd_eop_nxt;
      end
   end

   npu_pkt_ram #(
      .P_DEPTH  (DEPTH),
      .P_ADDR_W (ADDR_W),
      .P_DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (wr_data),
      .i_re    (w_re),
      .i_raddr (r_rptr[ADDR_W-1:0]),
      .o_rdata (w_rdata)
   );

   assign wr_err    = r_wr_err;
   assign rd_err    = r_rd_err;
   assign rd_vld    = r_rd_vld;
   assign rd_data   = w_rdata;
   assign rd_eop    = r_rd_eop;
   assign pkt_len   = r_pkt_len;
   assign pkt_valid = r_pkt_valid;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_npu_pkt_buffer.sv
module tb_npu_pkt_buffer;
   import npu_pkt_pkg::*;

   logic              clk;
   logic              rst;
   logic              wr_sop;
   logic              wr_vld;
   logic [DATA_W-1:0] wr_data;
   logic              wr_eop;
   logic              wr_err;
   logic              rd_sop;
   logic              rd_ready;
   logic              rd_vld;
   logic [DATA_W-1:0] rd_data;
   logic              rd_eop;
   logic              rd_err;
   logic [ADDR_W:0]   pkt_len;
   logic              pkt_valid;
   logic [1:0]        dbg_state;

   int n_checks;
   int n_errors;
   logic [DATA_W-1:0] exp_q[$];

   npu_pkt_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .wr_sop    (wr_sop),
      .wr_vld    (wr_vld),
      .wr_data   (wr_data),
      .wr_eop    (wr_eop),
      .wr_err    (wr_err),
      .rd_sop    (rd_sop),
      .rd_ready  (rd_ready),
      .rd_vld    (rd_vld),
      .rd_data   (rd_data),
      .rd_eop    (rd_eop),
      .rd_err    (rd_err),
      .pkt_len   (pkt_len),
      .pkt_valid (pkt_valid),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_sop();
      wr_sop = 1'b1;
      tick();
      wr_sop = 1'b0;
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d, output logic err);
      wr_vld  = 1'b1;
      wr_data = d;
      tick();
      err     = wr_err;
      wr_vld  = 1'b0;
      wr_data = '0;
   endtask

   task automatic pulse_eop();
      wr_eop = 1'b1;
      tick();
      wr_eop = 1'b0;
   endtask

   // Store a packet with error-free beats; fills exp_q with the same words.
   task automatic write_pkt(input string tag, input int n, input logic [DATA_W-1:0] base);
      logic e;
      pulse_sop();
      for (int i = 0; i < n; i++) begin
         send_beat(base + DATA_W'(i), e);
         exp_q.push_back(base + DATA_W'(i));
      end
      pulse_eop();
      check_eq({tag, "_len"}, 32'(pkt_len), n);
      check_eq({tag, "_valid"}, 32'(pkt_valid), 1);
   endtask

   // Read with rd_ready held high: beats on T+2 .. T+1+n, then IDLE.
   task automatic read_and_check(input string tag);
      int n;
      n = exp_q.size();
      rd_sop = 1'b1;
      tick();
      rd_sop = 1'b0;
      check_eq({tag, "_rd_err"}, 32'(rd_err), 0);
      check_eq({tag, "_lat_vld"}, 32'(rd_vld), 0);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq({tag, "_vld"}, 32'(rd_vld), 1);
         check_eq({tag, "_data"}, rd_data, exp_q.pop_front());
         check_eq({tag, "_eop"}, 32'(rd_eop), (i == n - 1) ? 1 : 0);
      end
      tick();
      check_eq({tag, "_end_vld"}, 32'(rd_vld), 0);
      check_eq({tag, "_end_data"}, rd_data, 0);
      check_eq({tag, "_end_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic       e;
      int         err_cnt;
      int         beat;
      logic [4:0] pat;

      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      wr_sop = 1'b0; wr_vld = 1'b0; wr_data = '0; wr_eop = 1'b0;
      rd_sop = 1'b0; rd_ready = 1'b1;
      tick();
      tick();
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
      check_eq("rst_vld", 32'(rd_vld), 0);
      check_eq("rst_data", rd_data, 0);
      check_eq("rst_len", 32'(pkt_len), 0);
      check_eq("rst_valid", 32'(pkt_valid), 0);
      check_eq("rst_errs", {30'd0, wr_err, rd_err}, 0);
      rst = 1'b0;
      tick();

      // 1) 4-word packet, eop two cycles after the last beat, then replay twice
      pulse_sop();
      check_eq("p4_state", 32'(dbg_state), 32'(WRITE));
      send_beat(32'h11, e); check_eq("p4_werr0", 32'(e), 0);
      send_beat(32'h22, e); check_eq("p4_werr1", 32'(e), 0);
      send_beat(32'h33, e); check_eq("p4_werr2", 32'(e), 0);
      send_beat(32'h44, e); check_eq("p4_werr3", 32'(e), 0);
      tick();
      tick();
      pulse_eop();
      check_eq("p4_len", 32'(pkt_len), 4);
      check_eq("p4_valid", 32'(pkt_valid), 1);
      check_eq("p4_eop_werr", 32'(wr_err), 0);
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      read_and_check("p4_rd");
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      read_and_check("p4_reread");

      // 2) overflow: DEPTH+1 beats
      pulse_sop();
      err_cnt = 0;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         send_beat(DATA_W'(i), e);
         if (e) err_cnt++;
         if (i == DEPTH + 1) check_eq("ovf_err_beat257", 32'(e), 1);
      end
      check_eq("ovf_err_count", err_cnt, 1);
      pulse_eop();
      check_eq("ovf_eop_werr", 32'(wr_err), 1);
      check_eq("ovf_valid", 32'(pkt_valid), 0);
      check_eq("ovf_len", 32'(pkt_len), DEPTH);
      tick();
      check_eq("ovf_werr_once", 32'(wr_err), 0);
      rd_sop = 1'b1;
      tick();
      rd_sop = 1'b0;
      check_eq("ovf_rd_err", 32'(rd_err), 1);
      check_eq("ovf_rd_state", 32'(dbg_state), 32'(IDLE));
      tick();
      check_eq("ovf_rd_err_pulse", 32'(rd_err), 0);
      check_eq("ovf_rd_novld", 32'(rd_vld), 0);

      // 3) protocol errors: vld in IDLE, sop mid-packet
      send_beat(32'hDEAD, e);
      check_eq("proto_idle_vld", 32'(e), 1);
      check_eq("proto_idle_state", 32'(dbg_state), 32'(IDLE));
      pulse_sop();
      send_beat(32'hB1, e);
      send_beat(32'hB2, e);
      send_beat(32'hB3, e);
      check_eq("proto_b3_werr", 32'(e), 0);
      pulse_sop();
      check_eq("proto_resop_werr", 32'(wr_err), 1);
      check_eq("proto_resop_state", 32'(dbg_state), 32'(WRITE));
      send_beat(32'hA1, e);
      check_eq("proto_a1_werr", 32'(e), 0);
      send_beat(32'hA2, e);
      pulse_eop();
      check_eq("proto_len", 32'(pkt_len), 2);
      check_eq("proto_valid", 32'(pkt_valid), 1);
      exp_q = '{32'hA1, 32'hA2};
      read_and_check("proto_rd");

      // 4) backpressure: 3-word packet, rd_ready 1,0,1,0,1
      exp_q.delete();
      write_pkt("bp_wr", 3, 32'hC1);
      rd_sop = 1'b1;
      tick();
      rd_sop = 1'b0;
      pat = 5'b10101;
      beat = 0;
      for (int i = 0; i < 5; i++) begin
         rd_ready = pat[i];
         tick();
         check_eq("bp_vld", 32'(rd_vld), 32'(pat[i]));
         if (pat[i]) begin
            beat++;
            check_eq("bp_data", rd_data, exp_q.pop_front());
            check_eq("bp_eop", 32'(rd_eop), (beat == 3) ? 1 : 0);
         end else begin
            check_eq("bp_gap_data", rd_data, 0);
         end
      end
      rd_ready = 1'b1;
      tick();
      check_eq("bp_beats", beat, 3);
      check_eq("bp_end_vld", 32'(rd_vld), 0);
      check_eq("bp_end_state", 32'(dbg_state), 32'(IDLE));

      // 5) collision: wr_sop+rd_sop in IDLE, then rd_sop during WRITE
      wr_sop = 1'b1;
      rd_sop = 1'b1;
      tick();
      wr_sop = 1'b0;
      rd_sop = 1'b0;
      check_eq("col_rd_err", 32'(rd_err), 1);
      check_eq("col_wr_err", 32'(wr_err), 0);
      check_eq("col_state", 32'(dbg_state), 32'(WRITE));
      send_beat(32'hD1, e);
      rd_sop = 1'b1;
      tick();
      rd_sop = 1'b0;
      check_eq("col_busy_rd_err", 32'(rd_err), 1);
      check_eq("col_busy_state", 32'(dbg_state), 32'(WRITE));
      send_beat(32'hD2, e);
      check_eq("col_d2_werr", 32'(e), 0);
      pulse_eop();
      check_eq("col_len", 32'(pkt_len), 2);
      check_eq("col_valid", 32'(pkt_valid), 1);
      exp_q = '{32'hD1, 32'hD2};
      read_and_check("col_rd");

      // 6) reset during beat 2 of an 8-word read
      exp_q.delete();
      write_pkt("rr_wr", 8, 32'hE0);
      rd_sop = 1'b1;
      tick();
      rd_sop = 1'b0;
      tick();
      tick();
      tick();
      check_eq("rr_beat2_data", rd_data, 32'hE2);
      check_eq("rr_beat2_vld", 32'(rd_vld), 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rr_vld", 32'(rd_vld), 0);
      check_eq("rr_data", rd_data, 0);
      check_eq("rr_eop", 32'(rd_eop), 0);
      check_eq("rr_valid", 32'(pkt_valid), 0);
      check_eq("rr_len", 32'(pkt_len), 0);
      check_eq("rr_state", 32'(dbg_state), 32'(IDLE));
      tick();
      rst = 1'b0;
      tick();
      check_eq("rr_post_state", 32'(dbg_state), 32'(IDLE));
      check_eq("rr_post_vld", 32'(rd_vld), 0);
      check_eq("rr_post_eop", 32'(rd_eop), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
